// File: rtl/hangy_turn_arbiter.sv
// Two-player turn scheduler for the hangy core: one buffered guess per player, miss passes the turn.
// Optional TURN_TIMEOUT_EN: forces a turn pass after TIMEOUT idle WAIT cycles.
module hangy_turn_arbiter #(
  parameter int LETTER_W = 5,
  parameter int SCORE_W  = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_game,
  input  logic [LETTER_W-1:0] p0_guess,
  input  logic [LETTER_W-1:0] p1_guess,
  input  logic                p0_valid,
  input  logic                p1_valid,
  output logic                p0_ready,
  output logic                p1_ready,
  output logic [LETTER_W-1:0] core_guess,
  output logic                core_valid,
  input  logic                core_ready,
  input  logic                core_done,
  input  logic                core_hit,
  input  logic                core_over,
  input  logic                core_win,
  output logic                cur_player,
  output logic                game_active,
  output logic [SCORE_W-1:0]  p0_score,
  output logic [SCORE_W-1:0]  p1_score,
  output logic                winner_valid,
  output logic                winner
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ISSUE, S_BUSY, S_OVER} state_t;

  state_t                          state_q, state_d;
  logic [1:0]                      full_q, full_d;
  logic [1:0][LETTER_W-1:0]        let_q, let_d;
  logic [1:0][SCORE_W-1:0]         score_q, score_d;
  logic                            cur_q, cur_d;
  logic                            winner_q, winner_d;
  logic                            wv_q, wv_d;
  logic [1:0]                      ready, cap;
  logic                            active, let_ok, hs, done, idle, tmo;

  assign active = (state_q == S_WAIT) || (state_q == S_ISSUE) || (state_q == S_BUSY);
  assign ready  = {2{active}} & ~full_q;
  assign cap    = {p1_valid, p0_valid} & ready;
  assign let_ok = (let_q[cur_q] != '0) && (let_q[cur_q] <= LETTER_W'(26));
  assign hs     = (state_q == S_ISSUE) && core_ready;
  assign done   = (state_q == S_BUSY) && core_done;
  assign idle   = (state_q == S_WAIT) && !full_q[cur_q];

`ifdef TURN_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only advances while the current player leaves its buffer empty in WAIT.
  assign tmo   = idle && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign cnt_d = (idle && !tmo && !new_game) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      full_q   <= '0;
      let_q    <= '0;
      score_q  <= '0;
      cur_q    <= 1'b0;
      winner_q <= 1'b0;
      wv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      full_q   <= full_d;
      let_q    <= let_d;
      score_q  <= score_d;
      cur_q    <= cur_d;
      winner_q <= winner_d;
      wv_q     <= wv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (new_game) state_d = S_WAIT;
    else begin
      case (state_q)
        S_WAIT:  if (full_q[cur_q] && let_ok) state_d = S_ISSUE;
        S_ISSUE: if (core_ready) state_d = S_BUSY;
        S_BUSY:  if (core_done) state_d = core_over ? S_OVER : S_WAIT;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    full_d   = full_q;
    let_d    = let_q;
    score_d  = score_q;
    cur_d    = cur_q;
    winner_d = winner_q;
    wv_d     = wv_q;
    if (new_game) begin
      full_d   = '0;
      score_d  = '0;
      cur_d    = 1'b0;
      winner_d = 1'b0;
      wv_d     = 1'b0;
    end else begin
      // Capture never collides with a free: ready is low while a buffer is full.
      if (cap[0]) begin full_d[0] = 1'b1; let_d[0] = p0_guess; end
      if (cap[1]) begin full_d[1] = 1'b1; let_d[1] = p1_guess; end
      if ((state_q == S_WAIT) && full_q[cur_q] && !let_ok) full_d[cur_q] = 1'b0;
      if (hs) full_d[cur_q] = 1'b0;
      if (done) begin
        if (core_hit && (score_q[cur_q] != '1)) score_d[cur_q] = score_q[cur_q] + 1'b1;
        if (core_over) begin
          winner_d = cur_q;
          wv_d     = core_win;
        end else if (!core_hit) begin
          cur_d = ~cur_q;
        end
      end
      if (tmo) cur_d = ~cur_q;
    end
  end

  always_comb begin
    core_valid   = (state_q == S_ISSUE);
    core_guess   = core_valid ? let_q[cur_q] : '0;
    game_active  = active;
    p0_ready     = ready[0];
    p1_ready     = ready[1];
    cur_player   = cur_q;
    p0_score     = score_q[0];
    p1_score     = score_q[1];
    winner       = winner_q;
    winner_valid = wv_q;
  end

endmodule

// File: tb/tb_hangy_turn_arbiter.sv
// Self-checking bench for hangy_turn_arbiter: per-cycle reference model plus directed literal checks.
module tb_hangy_turn_arbiter;
  localparam int LW = 5, SW = 4, TMO = 8;

  logic clk = 0, reset = 0, new_game = 0;
  logic [LW-1:0] p0_guess = 0, p1_guess = 0, core_guess;
  logic p0_valid = 0, p1_valid = 0, p0_ready, p1_ready;
  logic core_valid, core_ready = 0, core_done = 0, core_hit = 0, core_over = 0, core_win = 0;
  logic cur_player, game_active, winner_valid, winner;
  logic [SW-1:0] p0_score, p1_score;

  int checks = 0, failures = 0;

  hangy_turn_arbiter #(.LETTER_W(LW), .SCORE_W(SW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .new_game(new_game),
    .p0_guess(p0_guess), .p1_guess(p1_guess), .p0_valid(p0_valid), .p1_valid(p1_valid),
    .p0_ready(p0_ready), .p1_ready(p1_ready),
    .core_guess(core_guess), .core_valid(core_valid), .core_ready(core_ready),
    .core_done(core_done), .core_hit(core_hit), .core_over(core_over), .core_win(core_win),
    .cur_player(cur_player), .game_active(game_active),
    .p0_score(p0_score), .p1_score(p1_score),
    .winner_valid(winner_valid), .winner(winner));

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 wait, 2 issue, 3 busy, 4 over.
  int m_ph = 0, m_cur = 0, m_win = 0, m_wv = 0, m_idle = 0;
  int m_full[2] = '{0, 0};
  int m_let[2]  = '{0, 0};
  int m_sc[2]   = '{0, 0};

  always @(posedge clk or negedge reset) begin : model
    int ph, cur, win, wv, idl, act;
    int full[2], let_[2], sc[2];
    int vld[2], g[2];
    if (!reset) begin
      m_ph <= 0; m_cur <= 0; m_win <= 0; m_wv <= 0; m_idle <= 0;
      m_full <= '{0, 0}; m_let <= '{0, 0}; m_sc <= '{0, 0};
    end else begin
      ph = m_ph; cur = m_cur; win = m_win; wv = m_wv; idl = m_idle;
      full = m_full; let_ = m_let; sc = m_sc;
      vld[0] = p0_valid; vld[1] = p1_valid; g[0] = p0_guess; g[1] = p1_guess;
      if (new_game) begin
        ph = 1; cur = 0; win = 0; wv = 0; idl = 0;
        full = '{0, 0}; sc = '{0, 0};
      end else begin
        act = (m_ph >= 1 && m_ph <= 3);
        for (int n = 0; n < 2; n++)
          if (vld[n] && act && !m_full[n]) begin full[n] = 1; let_[n] = g[n]; end
        if (m_ph == 1 && m_full[m_cur]) begin
          if (m_let[m_cur] >= 1 && m_let[m_cur] <= 26) ph = 2;
          else full[m_cur] = 0;
        end else if (m_ph == 2 && core_ready) begin
          full[m_cur] = 0; ph = 3;
        end else if (m_ph == 3 && core_done) begin
          if (core_hit) sc[m_cur] = (m_sc[m_cur] == 15) ? 15 : m_sc[m_cur] + 1;
          if (core_over) begin ph = 4; win = m_cur; wv = core_win; end
          else begin ph = 1; if (!core_hit) cur = 1 - m_cur; end
        end
        idl = 0;
`ifdef TURN_TIMEOUT_EN
        if (m_ph == 1 && !m_full[m_cur]) begin
          if (m_idle + 1 == TMO) cur = 1 - m_cur;
          else idl = m_idle + 1;
        end
`endif
      end
      m_ph <= ph; m_cur <= cur; m_win <= win; m_wv <= wv; m_idle <= idl;
      m_full <= full; m_let <= let_; m_sc <= sc;
    end
  end

  always @(negedge clk) begin : compare
    int act;
    act = (m_ph >= 1 && m_ph <= 3);
    cmp("game_active", game_active, act);
    cmp("p0_ready", p0_ready, act && !m_full[0]);
    cmp("p1_ready", p1_ready, act && !m_full[1]);
    cmp("core_valid", core_valid, m_ph == 2);
    cmp("core_guess", core_guess, (m_ph == 2) ? m_let[m_cur] : 0);
    cmp("cur_player", cur_player, m_cur);
    cmp("p0_score", p0_score, m_sc[0]);
    cmp("p1_score", p1_score, m_sc[1]);
    cmp("winner", winner, m_win);
    cmp("winner_valid", winner_valid, m_wv);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_ng();
    new_game = 1; step(1); new_game = 0;
  endtask

  // Current player p offers a letter; the core accepts it and reports the result.
  task automatic play(input int p, input int l, input bit h, input bit o, input bit w);
    if (p == 0) begin p0_guess = LW'(l); p0_valid = 1; end
    else        begin p1_guess = LW'(l); p1_valid = 1; end
    step(1); p0_valid = 0; p1_valid = 0;
    step(1);
    core_ready = 1; step(1); core_ready = 0;
    core_done = 1; core_hit = h; core_over = o; core_win = w;
    step(1);
    core_done = 0; core_hit = 0; core_over = 0; core_win = 0;
  endtask

  task automatic chk_reset_vals();
    cmp("rst core_valid", core_valid, 0);
    cmp("rst core_guess", core_guess, 0);
    cmp("rst cur_player", cur_player, 0);
    cmp("rst p0_score", p0_score, 0);
    cmp("rst p1_score", p1_score, 0);
    cmp("rst ready", {p1_ready, p0_ready}, 0);
    cmp("rst game_active", game_active, 0);
    cmp("rst winner", {winner_valid, winner}, 0);
  endtask

  initial begin
    #13;
    chk_reset_vals();
    @(posedge clk); #2 reset = 1;
    step(1);
    cmp("idle game_active", game_active, 0);

    // Hit keeps the turn; hold core_ready low one cycle to see core_valid stay stable.
    pulse_ng();
    cmp("ng p0_ready", p0_ready, 1);
    p0_guess = 13; p0_valid = 1; step(1); p0_valid = 0;
    cmp("wait core_valid", core_valid, 0);
    step(1);
    cmp("issue core_valid", core_valid, 1);
    cmp("issue core_guess", core_guess, 13);
    step(1);
    cmp("held core_guess", core_guess, 13);
    core_ready = 1; step(1); core_ready = 0;
    cmp("hs drop core_valid", core_valid, 0);
    core_done = 1; core_hit = 1; step(1); core_done = 0; core_hit = 0;
    cmp("hit p0_score", p0_score, 1);
    cmp("hit cur_player", cur_player, 0);

    // p1 pre-loads o, p0 misses with a: turn passes and o issues next.
    p1_guess = 15; p1_valid = 1; step(1); p1_valid = 0;
    cmp("preload p1_ready", p1_ready, 0);
    play(0, 1, 0, 0, 0);
    cmp("miss cur_player", cur_player, 1);
    cmp("miss p1_ready", p1_ready, 0);
    step(1);
    cmp("p1 core_valid", core_valid, 1);
    cmp("p1 core_guess", core_guess, 15);
    core_ready = 1; step(1); core_ready = 0;
    cmp("p1 hs p1_ready", p1_ready, 1);
    core_done = 1; step(1); core_done = 0;
    cmp("p1 miss cur", cur_player, 0);

    // Out-of-range letters are dropped without issuing.
    for (int k = 0; k < 2; k++) begin
      p0_guess = (k == 0) ? 5'd0 : 5'd27; p0_valid = 1; step(1); p0_valid = 0;
      cmp("bad p0_ready low", p0_ready, 0);
      step(1);
      cmp("bad p0_ready back", p0_ready, 1);
      cmp("bad core_valid", core_valid, 0);
      cmp("bad cur", cur_player, 0);
    end

    // Word completed on p1's turn.
    play(0, 2, 0, 0, 0);
    play(1, 5, 1, 1, 1);
    cmp("over winner", winner, 1);
    cmp("over winner_valid", winner_valid, 1);
    cmp("over ready", {p1_ready, p0_ready}, 0);
    cmp("over p1_score", p1_score, 1);
    p0_guess = 4; p0_valid = 1; step(1); p0_valid = 0;
    cmp("over frozen p0_ready", p0_ready, 0);
    pulse_ng();
    cmp("restart cur", cur_player, 0);
    cmp("restart scores", {p1_score, p0_score}, 0);
    cmp("restart winner_valid", winner_valid, 0);

    // Saturation at 15.
    for (int k = 0; k < 16; k++) play(0, 3, 1, 0, 0);
    cmp("sat p0_score", p0_score, 15);

    // Abort mid-BUSY; a late core_done must be ignored.
    p0_guess = 7; p0_valid = 1; step(1); p0_valid = 0;
    step(1); core_ready = 1; step(1); core_ready = 0;
    pulse_ng();
    core_done = 1; core_hit = 1; step(1); core_done = 0; core_hit = 0;
    cmp("abort p0_score", p0_score, 0);
    cmp("abort core_valid", core_valid, 0);

    pulse_ng();
`ifdef TURN_TIMEOUT_EN
    step(TMO - 1);
    cmp("tmo before", cur_player, 0);
    step(1);
    cmp("tmo toggle", cur_player, 1);
`else
    step(1000);
    cmp("no tmo", cur_player, 0);
`endif

    // Asynchronous reset while BUSY.
    pulse_ng();
    p0_guess = 9; p0_valid = 1; step(1); p0_valid = 0;
    step(1); core_ready = 1; step(1); core_ready = 0;
    reset = 0; #1;
    chk_reset_vals();
    step(1); reset = 1; step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
